// File: rtl/sqrt_prenorm.sv
// FP32 square-root front-end: unpack, classify, normalize, and split the exponent for the mantissa core.
// Build with SQRT_PRENORM_DAZ_EN defined to treat every exp==0 input as a signed zero.

`ifndef SQRT_PRENORM_DAZ_EN
module lzc_sqrt (
  input  logic [22:0] value,
  output logic [4:0]  count
);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          count = count + 5'd1;
      end
    end
  end

endmodule
`endif

module sqrt_prenorm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_rad,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic [1:0]  out_class,
  output logic        out_nv
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_t;

  logic        s1_valid, s2_valid;
  logic        adv1, adv2;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        exp_max, exp_zero, frac_zero, zero_like;
  cls_t        in_cls;
  logic        in_nv;

  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_frac;
  cls_t        s1_cls;
  logic        s1_nv;

  logic [23:0] mant;
  logic signed [8:0] e_full;
  logic [24:0] rad_n;
  logic [7:0]  exp_n;
  logic        sign_n;

  assign adv2      = out_ready | ~s2_valid;
  assign adv1      = adv2 | ~s1_valid;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  assign in_sign   = in_operand[31];
  assign in_exp    = in_operand[30:23];
  assign in_frac   = in_operand[22:0];
  assign exp_max   = &in_exp;
  assign exp_zero  = ~|in_exp;
  assign frac_zero = ~|in_frac;

`ifdef SQRT_PRENORM_DAZ_EN
  assign zero_like = exp_zero;
`else
  assign zero_like = exp_zero & frac_zero;
`endif

  always_comb begin
    in_cls = CLS_NORMAL;
    in_nv  = 1'b0;
    if (exp_max) begin
      if (frac_zero && !in_sign) begin
        in_cls = CLS_INF;
      end else begin
        in_cls = CLS_NAN;
        // Quiet NaNs pass silently; sNaN and -inf raise invalid.
        in_nv  = frac_zero ? in_sign : ~in_frac[22];
      end
    end else if (zero_like) begin
      in_cls = CLS_ZERO;
    end else if (in_sign) begin
      in_cls = CLS_NAN;
      in_nv  = 1'b1;
    end
  end

`ifndef SQRT_PRENORM_DAZ_EN
  logic [4:0] lz_frac;
  logic [4:0] s1_shift;

  lzc_sqrt u_lzc (
    .value (in_frac),
    .count (lz_frac)
  );

  // Leading zeros of {1'b0,frac} are one more than those of frac alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_shift <= '0;
    end else if (adv1 && in_valid) begin
      s1_shift <= lz_frac + 5'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_cls   <= CLS_NORMAL;
      s1_nv    <= 1'b0;
    end else begin
      if (flush)     s1_valid <= 1'b0;
      else if (adv1) s1_valid <= in_valid;
      if (adv1 && in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_frac <= in_frac;
        s1_cls  <= in_cls;
        s1_nv   <= in_nv;
      end
    end
  end

  always_comb begin
    mant   = {1'b1, s1_frac};
    e_full = $signed({1'b0, s1_exp}) - 9'sd127;
`ifndef SQRT_PRENORM_DAZ_EN
    if (s1_exp == 8'h00) begin
      mant   = {1'b0, s1_frac} << s1_shift;
      e_full = -9'sd126 - $signed({4'b0000, s1_shift});
    end
`endif
    // Odd exponents move one factor of two into the radicand.
    rad_n  = e_full[0] ? {mant, 1'b0} : {1'b0, mant};
    exp_n  = e_full[8:1];
    sign_n = (s1_cls == CLS_ZERO) & s1_sign;
    if (s1_cls != CLS_NORMAL) begin
      rad_n = '0;
      exp_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_rad   <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_class <= 2'b00;
      out_nv    <= 1'b0;
    end else begin
      if (flush)     s2_valid <= 1'b0;
      else if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        out_rad   <= rad_n;
        out_exp   <= exp_n;
        out_sign  <= sign_n;
        out_class <= s1_cls;
        out_nv    <= s1_nv;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_prenorm.sv
// Scoreboard bench for sqrt_prenorm: directed IEEE cases, stalls, flush, reset and random traffic.
`timescale 1ns/1ps

module tb_sqrt_prenorm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_rad;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic [1:0]  out_class;
  logic        out_nv;

  sqrt_prenorm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rad    (out_rad),
    .out_exp    (out_exp),
    .out_sign   (out_sign),
    .out_class  (out_class),
    .out_nv     (out_nv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] rad;
    logic [7:0]  ex;
    logic        sign;
    logic [1:0]  cls;
    logic        nv;
  } res_t;

`ifdef SQRT_PRENORM_DAZ_EN
  localparam bit DAZ = 1'b1;
`else
  localparam bit DAZ = 1'b0;
`endif

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;
  res_t mon_got, mon_exp;

  logic [31:0] dops[16];
  res_t        dres[16];

  function automatic res_t model(input logic [31:0] op);
    res_t        r;
    logic        s;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [23:0] m;
    int          e;
    int          h;
    r  = '0;
    s  = op[31];
    ex = op[30:23];
    fr = op[22:0];
    if (ex == 8'hFF) begin
      r.cls = 2'b11;
      if (fr != 0)  r.nv = ~fr[22];
      else if (!s)  r.cls = 2'b10;
      else          r.nv = 1'b1;
    end else if (ex == 8'h00 && (fr == 0 || DAZ)) begin
      r.cls  = 2'b01;
      r.sign = s;
    end else if (s) begin
      r.cls = 2'b11;
      r.nv  = 1'b1;
    end else begin
      if (ex != 0) begin
        m = {1'b1, fr};
        e = int'(ex) - 127;
      end else begin
        m = {1'b0, fr};
        e = -126;
        while (!m[23]) begin
          m = m << 1;
          e--;
        end
      end
      if (e % 2 != 0) r.rad = {m, 1'b0};
      else            r.rad = {1'b0, m};
      h = e >>> 1;
      r.ex = 8'(h);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r = r & 32'h807F_000F;
      3: r[31] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_got = {out_rad, out_exp, out_sign, out_class, out_nv};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got rad=%h exp=%h sign=%b cls=%b nv=%b with empty scoreboard",
                 out_rad, out_exp, out_sign, out_class, out_nv);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard: got rad=%h exp=%h sign=%b cls=%b nv=%b, expected rad=%h exp=%h sign=%b cls=%b nv=%b",
                   mon_got.rad, mon_got.ex, mon_got.sign, mon_got.cls, mon_got.nv,
                   mon_exp.rad, mon_exp.ex, mon_exp.sign, mon_exp.cls, mon_exp.nv);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_table();
    dops[0]  = 32'h4080_0000; dres[0]  = {25'h080_0000, 8'h01, 1'b0, 2'b00, 1'b0};
    dops[1]  = 32'h4100_0000; dres[1]  = {25'h100_0000, 8'h01, 1'b0, 2'b00, 1'b0};
`ifdef SQRT_PRENORM_DAZ_EN
    dops[2]  = 32'h0000_0001; dres[2]  = {25'h000_0000, 8'h00, 1'b0, 2'b01, 1'b0};
    dops[9]  = 32'h8000_0001; dres[9]  = {25'h000_0000, 8'h00, 1'b1, 2'b01, 1'b0};
    dops[10] = 32'h0040_0000; dres[10] = {25'h000_0000, 8'h00, 1'b0, 2'b01, 1'b0};
`else
    dops[2]  = 32'h0000_0001; dres[2]  = {25'h100_0000, 8'hB5, 1'b0, 2'b00, 1'b0};
    dops[9]  = 32'h8000_0001; dres[9]  = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b1};
    dops[10] = 32'h0040_0000; dres[10] = {25'h100_0000, 8'hC0, 1'b0, 2'b00, 1'b0};
`endif
    dops[3]  = 32'hBF80_0000; dres[3]  = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b1};
    dops[4]  = 32'h8000_0000; dres[4]  = {25'h000_0000, 8'h00, 1'b1, 2'b01, 1'b0};
    dops[5]  = 32'h7F80_0001; dres[5]  = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b1};
    dops[6]  = 32'h7F80_0000; dres[6]  = {25'h000_0000, 8'h00, 1'b0, 2'b10, 1'b0};
    dops[7]  = 32'h7FC0_0000; dres[7]  = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b0};
    dops[8]  = 32'hFF80_0000; dres[8]  = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b1};
    dops[11] = 32'h3F80_0000; dres[11] = {25'h080_0000, 8'h00, 1'b0, 2'b00, 1'b0};
    dops[12] = 32'h0080_0000; dres[12] = {25'h080_0000, 8'hC1, 1'b0, 2'b00, 1'b0};
    dops[13] = 32'h7F7F_FFFF; dres[13] = {25'h1FF_FFFE, 8'h3F, 1'b0, 2'b00, 1'b0};
    dops[14] = 32'hFFC0_0000; dres[14] = {25'h000_0000, 8'h00, 1'b0, 2'b11, 1'b0};
    dops[15] = 32'h0000_0000; dres[15] = {25'h000_0000, 8'h00, 1'b0, 2'b01, 1'b0};
  endtask

  task automatic send_one(input logic [31:0] op, input res_t res);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_operand = op;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(res);
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL send_accept: operand %h not accepted within 50 cycles", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_operand = '0;
    #23;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    checks++;
    if ({out_rad, out_exp, out_sign, out_class, out_nv} !== 37'd0) begin
      errors++;
      $display("FAIL reset_data: rad=%h exp=%h sign=%b cls=%b nv=%b, required all zero",
               out_rad, out_exp, out_sign, out_class, out_nv);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_operand = 32'h4080_0000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: in_ready=%b, required 1", in_ready);
    end
    sb.push_back(dres[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_due: out_valid=%b two cycles after accept, required 1", out_valid);
    end
    drain("latency");
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_one(dops[i], dres[i]);
    drain("directed");
  endtask

  task automatic test_back_to_back();
    logic [31:0] op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      op = (i % 2 == 0) ? rand_op() : dops[i];
      in_valid = 1'b1; in_operand = op;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: in_ready=%b at beat %0d, required 1", in_ready, i);
      end else begin
        sb.push_back(model(op));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("b2b");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_operand = dops[0];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept_a: in_ready=%b, required 1", in_ready);
    end
    sb.push_back(dres[0]);
    @(posedge clk); #1;
    in_operand = dops[1];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept_b: in_ready=%b, required 1", in_ready);
    end
    sb.push_back(dres[1]);
    @(posedge clk); #1;
    in_operand = dops[11];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
      end
      checks++;
      if ({out_rad, out_exp, out_sign, out_class, out_nv} !== dres[0]) begin
        errors++;
        $display("FAIL bp_hold: rad=%h exp=%h, required rad=%h exp=%h",
                 out_rad, out_exp, dres[0].rad, dres[0].ex);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
    end
    sb.push_back(dres[11]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("backpressure");
  endtask

  task automatic test_random();
    int  sent;
    bit  acc;
    sent = 0;
    acc  = 1'b0;
    for (int cyc = 0; cyc < 2000 && sent < 60; cyc++) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_operand = rand_op();
        in_valid   = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(in_operand));
        sent++;
        acc = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 60) begin
      errors++; $display("FAIL random_sent: sent=%0d, required 60", sent);
    end
    drain("random");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_operand = dops[0];
    @(posedge clk); #1;
    in_operand = dops[1];
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_dropped: out_valid=%b after flush, required 0", out_valid);
      end
    end
    send_one(dops[12], dres[12]);
    drain("flush");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_operand = dops[13];
    @(posedge clk); #1;
    in_operand = dops[2];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rad !== 25'd0) begin
      errors++;
      $display("FAIL rstmid_async: out_valid=%b in_ready=%b rad=%h, required 0/1/0", out_valid, in_ready, out_rad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stale: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
    end
    send_one(dops[0], dres[0]);
    drain("rstmid");
  endtask

  initial begin
    build_table();
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_prenorm.md
Name: sqrt_prenorm

Overview:
- Two-stage valid/ready pipelined front-end for the FP32 square-root unit.
- Unpacks the operand and classifies special cases.
- Normalizes subnormal mantissas, using lzc_sqrt for the shift amount.
- Forces an even exponent, then hands {radicand, half-exponent, class} to the iterative sqrt mantissa core downstream.

Parameters:
- none. FP32 only; all widths are fixed.

Ports:
- clk        in   1   clock; all state updates on the rising edge
- rst_n      in   1   reset, asynchronous, active-low
- flush      in   1   synchronous kill of both pipeline stages
- in_valid   in   1   operand valid
- in_ready   out  1   stage 1 can accept an operand
- in_operand in   32  IEEE-754 single-precision radicand
- out_valid  out  1   result valid
- out_ready  in   1   downstream sqrt core accepts the result
- out_rad    out  25  radicand, 2 integer bits; value = out_rad*2^-23, in [1,4)
- out_exp    out  8   signed result exponent (unbiased), two's complement
- out_sign   out  1   result sign
- out_class  out  2   00 NORMAL, 01 ZERO, 10 INF, 11 NAN
- out_nv     out  1   invalid-operation flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valid flags and all data registers clear to 0.
  - out_valid=0, all out_* data=0, in_ready=1 while rst_n is low and after release.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - adv2 = out_ready | ~s2_valid.
  - adv1 = adv2 | ~s1_valid.
  - in_ready = adv1, combinational from registered state and out_ready only.
  - Latency is 2 cycles from acceptance to out_valid. Throughput is 1/cycle.
  - No loss or duplication under any stall pattern; order is preserved.
  - out_* data is held stable while out_valid && ~out_ready.
- flush: next edge clears s1_valid and s2_valid. flush dominates a simultaneous input transfer, so that operand is dropped.
- Stage 1 (register):
  - sign, exp[7:0], frac[22:0].
  - Classification:
    - exp==FF with frac!=0 -> NAN.
    - exp==FF with frac==0 -> INF if sign=0, else NAN.
    - exp==0 with frac==0 -> ZERO.
    - Any other negative value -> NAN.
    - Otherwise NORMAL.
  - Subnormal shift: s = leading zeros of 24-bit {1'b0,frac}, range 1..23. It is taken from lzc_sqrt, whose count output equals s-1 for this input.
- Stage 2 (register):
  - Normal input: m={1,frac}, e=exp-127.
  - Subnormal input: m={0,frac}<<s, e=-126-s. m[23]=1 is guaranteed.
  - e even: out_rad={1'b0,m}.
  - e odd: out_rad={m,1'b0}.
  - out_exp = e>>>1 (arithmetic shift). Range is -75..63, with no overflow.
- Special classes: out_rad=0, out_exp=0.
  - ZERO: out_sign = input sign (sqrt(-0) = -0).
  - INF: out_sign=0.
  - NAN: out_sign=0 (canonical).
- out_nv=1 iff the input is a signalling NaN (exp=FF, frac!=0, frac[22]=0) or a negative nonzero non-NaN, including -inf. Otherwise out_nv=0.
- Reset mid-operation: in-flight operands are discarded with no partial output.

Optional Feature:
- Macro: SQRT_PRENORM_DAZ_EN.
- Defined (denormals-are-zero):
  - Any input with exp==0 is classed ZERO with its sign kept and out_nv=0.
  - The lzc_sqrt instance and the subnormal shifter are not built.
- Undefined: subnormals are normalized as described under Behaviour.

Test Plan:
1. 0x40800000 (4.0), out_ready=1 -> 2 cycles later: out_rad=25'h0800000, out_exp=8'h01, NORMAL, out_nv=0.
2. 0x41000000 (8.0, odd exponent) -> out_rad=25'h1000000, out_exp=8'h01, NORMAL.
3. 0x00000001 (smallest subnormal) -> out_rad=25'h1000000, out_exp=8'hB5 (-75), NORMAL.
   - With DAZ enabled: ZERO, out_sign=0.
4. 0xBF800000 -> NAN, out_nv=1, out_sign=0.
   - 0x80000000 -> ZERO, out_sign=1, out_nv=0.
   - 0x7F800001 -> NAN, out_nv=1.
   - 0x7F800000 -> INF, out_nv=0.
5. Backpressure: 3 back-to-back operands with out_ready=0 -> 2 are accepted, then in_ready=0 and out_data is held. Raising out_ready drains all 3 in order.
6. Both stages valid, pull rst_n low mid-cycle -> out_valid=0 immediately. After release, in_ready=1 and no stale output appears.
   - Also: flush with in_valid=1 -> pipeline empty the next cycle and the operand is dropped.
